sdc_sector_responder: RTL and testbench
=======================================

Name: sdc_sector_responder

Overview:
- Serves the core's floppy sector-read requests (sdc_rd / sdc_sector) from a byte-stream storage backend.
- Returns each sector as 512 byte strobes, then pulses sdc_done.
- Sits between the host storage path and nanomig's sdc_* ports; it is the responder side of the core's sector interface.
- Throttles the backend so the core's byte sink never sees strobes closer than BYTE_GAP cycles.

Parameters:
- BYTE_GAP, 3: minimum idle cycles between consecutive sdc_byte_in_strobe pulses (0 = back-to-back allowed).
- TIMEOUT, 1000000: cycles without backend progress (ack or byte) before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk_sys  in  1  system clock (28.6875 MHz domain)
- reset_n  in  1  synchronous active-low reset
- sdc_rd  in  4  per-drive read request, level; held by core until sdc_busy seen
- sdc_sector  in  32  requested LBA, valid while any sdc_rd bit high
- sdc_busy  out  1  request accepted / transfer in progress
- sdc_done  out  1  one-cycle end-of-transfer pulse
- sdc_byte_in_strobe  out  1  one-cycle byte-valid pulse
- sdc_byte_in_addr  out  9  byte offset in sector, 0..511
- sdc_byte_in_data  out  8  byte value
- sdc_error  out  1  status of last transfer, valid from sdc_done until next acceptance
- mem_req  out  1  backend read request, held until mem_ack
- mem_lba  out  32  latched LBA
- mem_drive  out  2  latched drive index
- mem_ack  in  1  backend accepted request
- mem_valid  in  1  backend byte available
- mem_data  in  8  backend byte
- mem_ready  out  1  responder takes mem_data this cycle when mem_valid && mem_ready
- mem_error  in  1  backend failure, any time after mem_ack

Behaviour:
- Clock and reset: one clock, clk_sys. reset_n is synchronous, active-low. A low sample forces IDLE at the next edge, from any state, mid-transfer included.
- Reset values: all outputs 0; byte counter 0; gap counter 0; timeout counter 0.
- IDLE:
  - if |sdc_rd, pick the lowest set index. Latch the index into mem_drive and sdc_sector into mem_lba.
  - next cycle: sdc_busy=1, mem_req=1, sdc_error=0, go REQ.
  - sdc_rd bits sampled while not in IDLE are ignored; no queueing.
- REQ: mem_req held high. On mem_ack: mem_req=0 on the next cycle, go XFER.
- XFER:
  - mem_ready = 1 when the gap counter is 0.
  - on mem_valid && mem_ready: next cycle sdc_byte_in_strobe=1, with sdc_byte_in_data=mem_data and sdc_byte_in_addr=byte counter. The counter then increments.
  - gap counter loads BYTE_GAP. If BYTE_GAP>0, go GAP.
  - latency from accepted backend byte to strobe: exactly 1 cycle.
- GAP: mem_ready=0; decrement to 0, then return to XFER.
- End of sector:
  - the strobe for addr 511 ends the transfer. The counter wraps to 0 and is never used beyond 511.
  - next cycle: DONE.
- DONE:
  - sdc_done=1 for one cycle; sdc_busy falls in the same cycle; go IDLE.
  - a new request may be accepted the cycle after DONE (IDLE sampling).
- Timeout:
  - counter resets on every state change, mem_ack, and accepted byte; increments otherwise in REQ/XFER/GAP.
  - reaching TIMEOUT is treated as mem_error.
- Error (mem_error=1 in REQ/XFER/GAP, or timeout): sdc_error=1, mem_req=0, mem_ready=0, then handled per the optional feature.
- Simultaneous mem_valid and mem_error: error wins; the byte is discarded.
- mem_ack while not in REQ: ignored.
- sdc_busy stays 1 from acceptance through DONE inclusive of the cycle before sdc_done; it is 0 in the sdc_done cycle.

Optional Feature:
- Macro: SDC_ZEROFILL_EN.
- Defined: on error, the block enters FILL. Remaining addresses (current..511) are emitted as data 0x00, still honouring BYTE_GAP, then DONE with sdc_error=1. The core therefore always receives exactly 512 strobes per request.
- Undefined: on error, go directly to DONE the next cycle with sdc_error=1. No further strobes; the strobe count may be <512.

Test Plan:
- Basic read: sdc_rd=4'b0001, sdc_sector=32'h0000_00A0; backend acks after 5 cycles, bytes 0..255,0..255 always valid; BYTE_GAP=3 -> mem_lba=0xA0, mem_drive=0. 512 strobes, addr 0..511, data = addr[7:0], strobe spacing exactly 4 cycles. One sdc_done, sdc_error=0, busy low in done cycle.
- Priority: sdc_rd=4'b1010 -> mem_drive=1. While busy, change sdc_rd to 4'b0100 -> ignored until IDLE; next request then mem_drive=2.
- Backend stall: mem_valid low for 1000 cycles at byte 300, TIMEOUT=1000000 -> no error; strobes resume at addr 300; sector completes normally.
- Error mid-sector: mem_error at byte 100 -> with SDC_ZEROFILL_EN, strobes 100..511 carry 0x00 and sdc_error=1 at done. Without it, sdc_done the next cycle after error, 100 strobes total, sdc_error=1.
- Timeout: TIMEOUT=50, mem_ack never asserted -> error path taken after 50 cycles in REQ; mem_req drops; sdc_done pulses once.
- Reset mid-transfer: reset_n low at byte 200 for one cycle -> next edge all outputs 0, IDLE. A subsequent request restarts at addr 0 with fresh latched LBA.

Source files
------------

// File: rtl/sdc_sector_responder.sv
// Responder for the core's floppy sector reads: fetches a 512-byte sector from a byte-stream
// backend and replays it as paced byte strobes followed by a done pulse. Macro SDC_ZEROFILL_EN
// pads aborted sectors with 0x00 bytes so the core always sees 512 strobes.
module sdc_sector_responder #(
  parameter int unsigned BYTE_GAP = 3,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [3:0]  sdc_rd,
  input  logic [31:0] sdc_sector,
  output logic        sdc_busy,
  output logic        sdc_done,
  output logic        sdc_byte_in_strobe,
  output logic [8:0]  sdc_byte_in_addr,
  output logic [7:0]  sdc_byte_in_data,
  output logic        sdc_error,
  output logic        mem_req,
  output logic [31:0] mem_lba,
  output logic [1:0]  mem_drive,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic [7:0]  mem_data,
  output logic        mem_ready,
  input  logic        mem_error
);

  localparam int unsigned GW = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GapLoad = GW'(BYTE_GAP);
  // Compared against the current count so the abort lands after exactly TIMEOUT idle cycles.
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StXfer, StGap, StDone, StFill} state_e;

  state_e        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_strobe;
  logic [8:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_error;
  logic          r_mem_req;
  logic [31:0]   r_lba;
  logic [1:0]    r_drive;
  logic          r_ready;
  logic [8:0]    r_cnt;
  logic [GW-1:0] r_gap;
  logic [TW-1:0] r_to;

  logic [1:0]    w_drive;
  logic          w_active;
  logic          w_fail;
  logic          w_last;

  always_comb begin
    w_drive = 2'd0;
    if (sdc_rd[0])      w_drive = 2'd0;
    else if (sdc_rd[1]) w_drive = 2'd1;
    else if (sdc_rd[2]) w_drive = 2'd2;
    else if (sdc_rd[3]) w_drive = 2'd3;
  end

  assign w_active = (r_state == StReq) || (r_state == StXfer) || (r_state == StGap);
  // Error beats a simultaneous byte: the failure branch below takes precedence over XFER.
  assign w_fail   = w_active && (mem_error || (r_to == ToLast));
  assign w_last   = (r_cnt == 9'd511);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_strobe  <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_error   <= 1'b0;
      r_mem_req <= 1'b0;
      r_lba     <= '0;
      r_drive   <= '0;
      r_ready   <= 1'b0;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_to      <= '0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (w_fail) begin
        r_error   <= 1'b1;
        r_mem_req <= 1'b0;
        r_ready   <= 1'b0;
        r_to      <= '0;
`ifdef SDC_ZEROFILL_EN
        r_state   <= StFill;
        // Carry the pending gap over so padding keeps the pacing of the last real byte.
        r_gap     <= (r_gap != '0) ? r_gap - GW'(1) : '0;
`else
        r_state   <= StDone;
`endif
      end else begin
        unique case (r_state)
          StIdle: begin
            r_to <= '0;
            if (|sdc_rd) begin
              r_drive   <= w_drive;
              r_lba     <= sdc_sector;
              r_busy    <= 1'b1;
              r_mem_req <= 1'b1;
              r_error   <= 1'b0;
              r_cnt     <= '0;
              r_gap     <= '0;
              r_state   <= StReq;
            end
          end
          StReq: begin
            if (mem_ack) begin
              r_mem_req <= 1'b0;
              r_ready   <= 1'b1;
              r_to      <= '0;
              r_state   <= StXfer;
            end else begin
              r_to <= r_to + TW'(1);
            end
          end
          StXfer: begin
            if (mem_valid && r_ready) begin
              r_strobe <= 1'b1;
              r_addr   <= r_cnt;
              r_data   <= mem_data;
              r_cnt    <= r_cnt + 9'd1;
              r_to     <= '0;
              if (w_last) begin
                r_ready <= 1'b0;
                r_state <= StDone;
              end else if (BYTE_GAP > 0) begin
                r_gap   <= GapLoad;
                r_ready <= 1'b0;
                r_state <= StGap;
              end
            end else begin
              r_to <= r_to + TW'(1);
            end
          end
          StGap: begin
            if (r_gap <= GW'(1)) begin
              r_gap   <= '0;
              r_ready <= 1'b1;
              r_to    <= '0;
              r_state <= StXfer;
            end else begin
              r_gap <= r_gap - GW'(1);
              r_to  <= r_to + TW'(1);
            end
          end
`ifdef SDC_ZEROFILL_EN
          StFill: begin
            if (r_gap != '0) begin
              r_gap <= r_gap - GW'(1);
            end else begin
              r_strobe <= 1'b1;
              r_addr   <= r_cnt;
              r_data   <= 8'h00;
              r_cnt    <= r_cnt + 9'd1;
              r_gap    <= GapLoad;
              if (w_last) r_state <= StDone;
            end
          end
`endif
          StDone: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_to    <= '0;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign sdc_busy           = r_busy;
  assign sdc_done           = r_done;
  assign sdc_byte_in_strobe = r_strobe;
  assign sdc_byte_in_addr   = r_addr;
  assign sdc_byte_in_data   = r_data;
  assign sdc_error          = r_error;
  assign mem_req            = r_mem_req;
  assign mem_lba            = r_lba;
  assign mem_drive          = r_drive;
  assign mem_ready          = r_ready;

endmodule

// File: tb/tb_sdc_sector_responder.sv
// Bench for sdc_sector_responder: table of sector requests driven through a backend model,
// strobes checked against a scoreboard, plus a hand-written timeout sequence on a second instance.
`timescale 1ns/1ps
module tb_sdc_sector_responder;

  localparam int Gap = 3;
`ifdef SDC_ZEROFILL_EN
  localparam bit ZeroFill = 1'b1;
`else
  localparam bit ZeroFill = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  sdc_rd;
  logic [31:0] sdc_sector;
  logic        sdc_busy, sdc_done, sdc_byte_in_strobe, sdc_error;
  logic [8:0]  sdc_byte_in_addr;
  logic [7:0]  sdc_byte_in_data;
  logic        mem_req, mem_ack, mem_valid, mem_ready, mem_error;
  logic [31:0] mem_lba;
  logic [1:0]  mem_drive;
  logic [7:0]  mem_data;

  logic [3:0]  t_rd;
  logic        t_busy, t_done, t_strobe, t_error, t_req, t_ready;
  logic [8:0]  t_addr;
  logic [7:0]  t_data;
  logic [31:0] t_lba;
  logic [1:0]  t_drive;
  logic        t_ack = 1'b0, t_valid = 1'b0, t_merr = 1'b0;
  logic [7:0]  t_mdata = 8'h00;

  sdc_sector_responder #(.BYTE_GAP(Gap), .TIMEOUT(1000000)) dut (
    .clk_sys(clk), .reset_n(reset_n), .sdc_rd(sdc_rd), .sdc_sector(sdc_sector),
    .sdc_busy(sdc_busy), .sdc_done(sdc_done), .sdc_byte_in_strobe(sdc_byte_in_strobe),
    .sdc_byte_in_addr(sdc_byte_in_addr), .sdc_byte_in_data(sdc_byte_in_data),
    .sdc_error(sdc_error), .mem_req(mem_req), .mem_lba(mem_lba), .mem_drive(mem_drive),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
    .mem_error(mem_error)
  );

  sdc_sector_responder #(.BYTE_GAP(0), .TIMEOUT(50)) dut_t (
    .clk_sys(clk), .reset_n(reset_n), .sdc_rd(t_rd), .sdc_sector(32'h0000_0042),
    .sdc_busy(t_busy), .sdc_done(t_done), .sdc_byte_in_strobe(t_strobe),
    .sdc_byte_in_addr(t_addr), .sdc_byte_in_data(t_data), .sdc_error(t_error),
    .mem_req(t_req), .mem_lba(t_lba), .mem_drive(t_drive), .mem_ack(t_ack),
    .mem_valid(t_valid), .mem_data(t_mdata), .mem_ready(t_ready), .mem_error(t_merr)
  );

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  rd_busy;
    logic [31:0] sector;
    int          ack_dly;
    int          err_at;
    int          stall_at;
    int          stall_len;
    int          rst_at;
    logic [1:0]  exp_drive;
    int          exp_n;
    logic        exp_err;
    bit          exact;
  } txn_t;

  exp_t sb[$];
  int   n_tests, n_fail, cyc, cur_id;
  int   bidx, fill_addr, n_strobe, n_done, last_strobe, done_cyc;
  bit   exact_gap;
  logic prev_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [txn %0d] %s: got 0x%0h, want 0x%0h (cycle %0d)", cur_id, name, act, exp,
               cyc);
    end
  endtask

  // One clock: record a backend handshake as an expected strobe, then check what the DUT shows.
  task automatic tick();
    logic hs;
    exp_t e;
    bit   from_sb;
    hs = mem_valid && mem_ready && !mem_error;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      e.addr = 9'(bidx);
      e.data = 8'(bidx);
      e.cyc  = cyc;
      sb.push_back(e);
      bidx++;
    end
    if (sdc_byte_in_strobe) begin
      n_strobe++;
      chk("strobe expected", 32'(sb.size() != 0 || fill_addr >= 0), 1);
      from_sb = (sb.size() != 0);
      if (from_sb) e = sb.pop_front();
      else begin
        e.addr = 9'(fill_addr);
        e.data = 8'h00;
        fill_addr++;
      end
      chk("strobe addr", 32'(sdc_byte_in_addr), 32'(e.addr));
      chk("strobe data", 32'(sdc_byte_in_data), 32'(e.data));
      if (from_sb) chk("strobe latency", cyc, e.cyc);
      if (last_strobe >= 0) begin
        if (exact_gap) chk("strobe spacing", cyc - last_strobe, Gap + 1);
        else chk("strobe spacing min", 32'(cyc - last_strobe >= Gap + 1), 1);
      end
      last_strobe = cyc;
    end
    if (sdc_done) begin
      n_done++;
      done_cyc = cyc;
      chk("busy low in done cycle", 32'(sdc_busy), 0);
      chk("busy high before done", 32'(prev_busy), 1);
    end
    prev_busy = sdc_busy;
  endtask

  task automatic check_idle(input string name);
    chk({name, " mem_lba"}, mem_lba, 0);
    chk({name, " ctl"}, 32'({sdc_busy, sdc_done, sdc_byte_in_strobe, sdc_byte_in_addr,
                             sdc_byte_in_data, sdc_error, mem_req, mem_drive, mem_ready}), 0);
  endtask

  task automatic run_txn(input txn_t t, input int id);
    bit seen;
    int err_cyc, stall_cnt;
    cur_id = id;
    sb.delete();
    bidx = 0; fill_addr = -1; n_strobe = 0; n_done = 0; last_strobe = -1; done_cyc = -1;
    exact_gap = t.exact; err_cyc = -1; stall_cnt = 0; seen = 1'b0;
    sdc_sector = t.sector;
    sdc_rd = t.rd;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      seen = sdc_busy;
    end
    chk("busy after request", 32'(seen), 1);
    sdc_rd = t.rd_busy;
    sdc_sector = 32'hDEAD_BEEF;
    chk("mem_req on accept", 32'(mem_req), 1);
    chk("mem_lba", mem_lba, t.sector);
    chk("mem_drive", 32'(mem_drive), 32'(t.exp_drive));
    chk("error cleared on accept", 32'(sdc_error), 0);
    repeat (t.ack_dly) tick();
    chk("mem_req held until ack", 32'(mem_req), 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("mem_req drops after ack", 32'(mem_req), 0);
    chk("mem_ready after ack", 32'(mem_ready), 1);
    for (int k = 0; k < 8000 && n_done == 0; k++) begin
      mem_valid = 1'b1;
      mem_data  = 8'(bidx);
      mem_error = 1'b0;
      if (t.rst_at >= 0 && bidx == t.rst_at) begin
        reset_n = 1'b0;
        mem_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        check_idle("after mid-transfer reset");
        sdc_rd = '0;
        return;
      end
      if (t.stall_at >= 0 && bidx == t.stall_at && stall_cnt < t.stall_len) begin
        mem_valid = 1'b0;
        stall_cnt++;
      end
      if (t.err_at >= 0 && bidx == t.err_at && err_cyc < 0) begin
        mem_error = 1'b1;  // valid stays high too: the byte must be dropped
        tick();
        err_cyc = cyc;
        mem_error = 1'b0;
        mem_valid = 1'b0;
`ifdef SDC_ZEROFILL_EN
        fill_addr = bidx;
`endif
        continue;
      end
      if (err_cyc >= 0) mem_valid = 1'b0;
      tick();
    end
    mem_valid = 1'b0;
    sdc_rd = '0;
    repeat (3) tick();
    chk("exactly one done", n_done, 1);
    chk("strobe count", n_strobe, t.exp_n);
    chk("sdc_error at end", 32'(sdc_error), 32'(t.exp_err));
    chk("mem_drive kept", 32'(mem_drive), 32'(t.exp_drive));
    chk("scoreboard drained", sb.size(), 0);
    if (!t.exp_err) chk("done follows last strobe", done_cyc - last_strobe, 1);
`ifndef SDC_ZEROFILL_EN
    else chk("done after error", done_cyc - err_cyc, 1);
`endif
  endtask

  function automatic txn_t mk(input logic [3:0] rd, input logic [3:0] rd_busy,
                              input logic [31:0] sector, input int ack_dly, input int err_at,
                              input int stall_at, input int stall_len, input int rst_at,
                              input logic [1:0] drv, input int n, input logic err,
                              input bit exact);
    txn_t t;
    t.rd = rd; t.rd_busy = rd_busy; t.sector = sector; t.ack_dly = ack_dly;
    t.err_at = err_at; t.stall_at = stall_at; t.stall_len = stall_len; t.rst_at = rst_at;
    t.exp_drive = drv; t.exp_n = n; t.exp_err = err; t.exact = exact;
    return t;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tv[8];
    bit   seen;
    int   req_cycles, t_nstb, t_ndone;
    n_tests = 0; n_fail = 0; cyc = 0; cur_id = -1;
    bidx = 0; fill_addr = -1; n_strobe = 0; n_done = 0; last_strobe = -1; done_cyc = -1;
    exact_gap = 1'b0; prev_busy = 1'b0;
    reset_n = 1'b0; sdc_rd = '0; sdc_sector = '0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0; mem_error = 1'b0; t_rd = '0;

    tv[0] = mk(4'b0001, 4'b0000, 32'h0000_00A0, 5, -1, -1, 0, -1, 2'd0, 512, 1'b0, 1'b1);
    tv[1] = mk(4'b1010, 4'b0100, 32'h1234_5678, 0, -1, -1, 0, -1, 2'd1, 512, 1'b0, 1'b1);
    tv[2] = mk(4'b0100, 4'b0000, 32'h0000_0200, 2, -1, -1, 0, -1, 2'd2, 512, 1'b0, 1'b1);
    tv[3] = mk(4'b1000, 4'b0000, 32'hFFFF_FFFF, 1, -1, 300, 1000, -1, 2'd3, 512, 1'b0, 1'b0);
    tv[4] = mk(4'b0001, 4'b0000, 32'h0000_0007, 3, 100, -1, 0, -1, 2'd0,
               ZeroFill ? 512 : 100, 1'b1, 1'b1);
    tv[5] = mk(4'b0110, 4'b0000, 32'h0000_0008, 0, 0, -1, 0, -1, 2'd1,
               ZeroFill ? 512 : 0, 1'b1, 1'b1);
    tv[6] = mk(4'b0001, 4'b0000, 32'h0000_BEEF, 1, -1, -1, 0, 200, 2'd0, 0, 1'b0, 1'b1);
    tv[7] = mk(4'b0011, 4'b0000, 32'h0000_0055, 4, -1, -1, 0, -1, 2'd0, 512, 1'b0, 1'b1);

    repeat (3) tick();
    check_idle("reset");
    chk("timeout dut reset ctl", 32'({t_busy, t_done, t_strobe, t_error, t_req, t_ready}), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_txn(tv[i], i);

    // Backend never acks: the short-timeout instance must abort out of REQ.
    cur_id = 100;
    seen = 1'b0; req_cycles = 0; t_nstb = 0; t_ndone = 0;
    t_rd = 4'b0100;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      seen = t_busy;
    end
    chk("timeout busy after request", 32'(seen), 1);
    t_rd = '0;
    chk("timeout mem_drive", 32'(t_drive), 2);
    chk("timeout mem_lba", t_lba, 32'h0000_0042);
    for (int k = 0; k < 700; k++) begin
      if (t_req) req_cycles++;
      tick();
      if (t_strobe) begin
        chk("timeout fill addr", 32'(t_addr), t_nstb);
        chk("timeout fill data", 32'(t_data), 0);
        t_nstb++;
      end
      if (t_done) begin
        t_ndone++;
        chk("timeout busy low at done", 32'(t_busy), 0);
      end
    end
    chk("timeout mem_req high cycles", req_cycles, 50);
    chk("timeout single done", t_ndone, 1);
    chk("timeout sdc_error", 32'(t_error), 1);
    chk("timeout strobe count", t_nstb, ZeroFill ? 512 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
